mem_ctrl: RTL and testbench

Memory access sequencer between the address register and the 8-bit synchronous RAM. It consumes the 16-bit address held in the address register and performs byte reads, byte writes and little-endian 16-bit word reads, which are used for address operands. For word reads it steps the address itself and issues a one-cycle increment pulse back to the address register, so the register stays consistent. The controller drives it through a req/ack handshake.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_ctrl_if.sv | 35 +++
 rtl/mem_ctrl.sv | 132 +++++++++++++
 tb/tb_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory access sequencer and the controller that drives it.
// Op codes and FSM states live here so both sides decode the same values.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_RDB = 2'b00,
    OP_WRB = 2'b01,
    OP_RDW = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR    = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mem_ctrl_if.sv
// Controller/RAM-facing bundle of the memory sequencer; dbg_state mirrors the FSM for checkers.
// Handshake: req is sampled only while idle; ack is a one-cycle pulse, busy spans accept..ack inclusive.
interface mem_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  import mem_ctrl_pkg::*;

  logic                  req;
  logic [1:0]            op;
  logic [ADDR_W-1:0]     addr_in;
  logic [DATA_W-1:0]     wdata;
  logic [2*DATA_W-1:0]   rdata;
  logic                  ack;
  logic                  err;
  logic                  busy;
  logic                  arinc_out;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DATA_W-1:0]     mem_rdata;
  state_e                dbg_state;

  modport master (
    output req, op, addr_in, wdata, mem_rdata,
    input  rdata, ack, err, busy, arinc_out, mem_addr, mem_wdata, mem_rd, mem_wr, dbg_state
  );

  modport slave (
    input  req, op, addr_in, wdata, mem_rdata,
    output rdata, ack, err, busy, arinc_out, mem_addr, mem_wdata, mem_rd, mem_wr, dbg_state
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory access sequencer: byte read/write and little-endian word read against an 8-bit RAM.
// Word reads step the address internally and pulse arinc_out so the address register tracks it.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e              state;
  logic [3:0]          cnt;
  logic                word_q;
  logic [2*DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mwdata_q;
  logic                ack_q;
  logic                err_q;
  logic                busy_q;
  logic                arinc_q;
  logic                rd_q;
  logic                wr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      word_q   <= 1'b0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      arinc_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req) begin
            maddr_q <= bus.addr_in;
            busy_q  <= 1'b1;
            cnt     <= CNT_LOAD;
            word_q  <= (bus.op == OP_RDW);
            case (op_e'(bus.op))
              OP_RDB, OP_RDW: begin
                rd_q  <= 1'b1;
                state <= ST_RD_LO;
              end
              OP_WRB: begin
                mwdata_q <= bus.wdata;
                wr_q     <= 1'b1;
                state    <= ST_WR;
              end
              default: begin
                // Reserved op completes immediately with an error and never touches RAM.
                ack_q <= 1'b1;
                err_q <= 1'b1;
                state <= ST_DONE;
              end
            endcase
          end
        end
        ST_RD_LO: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata_q[DATA_W-1:0] <= bus.mem_rdata;
            if (word_q) begin
              // High byte sits at the next address; mem_rd stays asserted across the step.
              maddr_q <= maddr_q + ADDR_W'(1);
              arinc_q <= 1'b1;
              cnt     <= CNT_LOAD;
              state   <= ST_RD_HI;
            end else begin
              rdata_q[2*DATA_W-1:DATA_W] <= '0;
              rd_q  <= 1'b0;
              ack_q <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_RD_HI: begin
          arinc_q <= 1'b0;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rdata_q[2*DATA_W-1:DATA_W] <= bus.mem_rdata;
            rd_q  <= 1'b0;
            ack_q <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_WR: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            wr_q  <= 1'b0;
            ack_q <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.arinc_out = arinc_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (1 and 3 wait cycles) sharing a RAM model, one selected per access.
// Expected timing and data come from a transaction-level model of the access rules.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] addr_in = '0;
  logic [7:0]  wdata = '0;
  int          sel = 0;

  logic [7:0]  ram [0:65535];
  logic [15:0] last_rd [2];
  logic [15:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  mem_ctrl_if #(.ADDR_W(16), .DATA_W(8)) if1 ();
  mem_ctrl_if #(.ADDR_W(16), .DATA_W(8)) if3 ();

  mem_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(1)) dut  (.clk(clk), .rst(rst), .bus(if1.slave));
  mem_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  assign if1.req = req & (sel == 0);
  assign if3.req = req & (sel == 1);
  assign if1.op = op;          assign if3.op = op;
  assign if1.addr_in = addr_in; assign if3.addr_in = addr_in;
  assign if1.wdata = wdata;    assign if3.wdata = wdata;
  assign if1.mem_rdata = ram[if1.mem_addr];
  assign if3.mem_rdata = ram[if3.mem_addr];

  // Observation of the currently selected instance.
  wire [15:0] o_rdata = sel ? if3.rdata : if1.rdata;
  wire        o_ack   = sel ? if3.ack : if1.ack;
  wire        o_err   = sel ? if3.err : if1.err;
  wire        o_busy  = sel ? if3.busy : if1.busy;
  wire        o_inc   = sel ? if3.arinc_out : if1.arinc_out;
  wire [15:0] o_addr  = sel ? if3.mem_addr : if1.mem_addr;
  wire [7:0]  o_wdat  = sel ? if3.mem_wdata : if1.mem_wdata;
  wire        o_rd    = sel ? if3.mem_rd : if1.mem_rd;
  wire        o_wr    = sel ? if3.mem_wr : if1.mem_wr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on instance s; pulse_k >= 0 raises a stray req at that sample to check it is ignored.
  task automatic run_txn(input int s, input logic [1:0] o, input logic [15:0] a,
                         input logic [7:0] d, input int pulse_k);
    int w, n, ack_at, rd_cnt, wr_cnt, inc_cnt, inc_at, exp_rd, exp_wr, exp_inc;
    logic [15:0] a1, exp_addr, exp_data;
    sel = s;
    w = (s == 1) ? 3 : 1;
    a1 = a + 16'd1;
    n = (o == OP_RSV) ? 0 : (o == OP_RDW) ? 2 * w : w;
    exp_rd  = (o == OP_RDB || o == OP_RDW) ? n : 0;
    exp_wr  = (o == OP_WRB) ? w : 0;
    exp_inc = (o == OP_RDW) ? 1 : 0;
    if (o == OP_RDB)      exp_q.push_back({8'h00, ram[a]});
    else if (o == OP_RDW) exp_q.push_back({ram[a1], ram[a]});
    else                  exp_q.push_back(last_rd[s]);
    req = 1'b1; op = o; addr_in = a; wdata = d;
    step();
    req = 1'b0;
    ack_at = -1; rd_cnt = 0; wr_cnt = 0; inc_cnt = 0; inc_at = -1;
    for (int k = 0; k <= 40 && ack_at < 0; k++) begin
      if (k > 0) step();
      if (k == pulse_k) begin req = 1'b1; op = OP_RDB; end
      else if (k == pulse_k + 1) req = 1'b0;
      if (o_rd) rd_cnt++;
      if (o_wr) wr_cnt++;
      if (o_inc) begin inc_cnt++; inc_at = k; end
      checks++;
      if (!o_busy || (o_rd && o_wr)) begin
        failures++;
        $display("FAIL busy_excl s=%0d k=%0d: busy=%b rd=%b wr=%b, need busy=1 and not rd&wr", s, k, o_busy, o_rd, o_wr);
      end
      exp_addr = (o == OP_RDW && k >= w) ? a1 : a;
      if (o_rd || o_wr) begin
        checks++;
        if (o_addr !== exp_addr) begin
          failures++;
          $display("FAIL mem_addr s=%0d k=%0d: got %h need %h", s, k, o_addr, exp_addr);
        end
      end
      if (o_wr) begin
        checks++;
        if (o_wdat !== d) begin
          failures++;
          $display("FAIL mem_wdata s=%0d k=%0d: got %h need %h", s, k, o_wdat, d);
        end
      end
      if (o_ack) ack_at = k;
    end
    req = 1'b0;
    exp_data = exp_q.pop_front();
    checks++;
    if (ack_at != n) begin
      failures++;
      $display("FAIL ack_latency s=%0d op=%0d: got %0d need %0d", s, o, ack_at, n);
    end
    checks++;
    if (rd_cnt != exp_rd || wr_cnt != exp_wr) begin
      failures++;
      $display("FAIL strobe_len s=%0d op=%0d: rd=%0d wr=%0d need rd=%0d wr=%0d", s, o, rd_cnt, wr_cnt, exp_rd, exp_wr);
    end
    checks++;
    if (inc_cnt != exp_inc || (exp_inc == 1 && inc_at != w)) begin
      failures++;
      $display("FAIL arinc s=%0d op=%0d: pulses=%0d at=%0d need %0d at %0d", s, o, inc_cnt, inc_at, exp_inc, w);
    end
    checks++;
    if (o_err !== (o == OP_RSV) || o_rdata !== exp_data) begin
      failures++;
      $display("FAIL ack_data s=%0d op=%0d: err=%b rdata=%h need err=%b rdata=%h", s, o, o_err, o_rdata, (o == OP_RSV), exp_data);
    end
    last_rd[s] = exp_data;
    if (o == OP_WRB) ram[a] = d;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (o_ack || o_err || o_busy || o_rd || o_wr || o_inc) begin
        failures++;
        $display("FAIL post_idle s=%0d k=%0d: ack=%b err=%b busy=%b rd=%b wr=%b inc=%b, need all 0", s, k, o_ack, o_err, o_busy, o_rd, o_wr, o_inc);
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({if1.rdata, if1.ack, if1.err, if1.busy, if1.arinc_out, if1.mem_addr, if1.mem_wdata, if1.mem_rd, if1.mem_wr,
         if3.rdata, if3.ack, if3.err, if3.busy, if3.arinc_out, if3.mem_addr, if3.mem_wdata, if3.mem_rd, if3.mem_wr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: w1 rdata=%h addr=%h busy=%b, w3 rdata=%h addr=%h busy=%b, need all 0",
               if1.rdata, if1.mem_addr, if1.busy, if3.rdata, if3.mem_addr, if3.busy);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_byte_read();
    ram[16'h1234] = 8'hA5;
    run_txn(0, OP_RDB, 16'h1234, 8'h00, -1);
  endtask

  task automatic test_word_wrap();
    ram[16'hFFFF] = 8'h34;
    ram[16'h0000] = 8'h12;
    run_txn(0, OP_RDW, 16'hFFFF, 8'h00, -1);
    checks++;
    if (o_rdata !== 16'h1234) begin
      failures++;
      $display("FAIL word_wrap_value: got %h need 1234", o_rdata);
    end
  endtask

  task automatic test_write_w3();
    ram[16'h0077] = 8'h3C;
    run_txn(1, OP_RDB, 16'h0077, 8'h00, -1);
    run_txn(1, OP_WRB, 16'h0040, 8'h5A, -1);
    checks++;
    if (o_rdata !== 16'h003C) begin
      failures++;
      $display("FAIL write_keeps_rdata: got %h need 003c", o_rdata);
    end
  endtask

  task automatic test_reserved();
    run_txn(0, OP_RSV, 16'h0123, 8'hFF, -1);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    sel = 0;
    req = 1'b1; op = OP_RDB; addr_in = a;
    step();
    step();
    checks++;
    if (!o_ack || o_rdata !== {8'h00, ram[a]}) begin
      failures++;
      $display("FAIL b2b_first: ack=%b rdata=%h need ack=1 rdata=%h", o_ack, o_rdata, {8'h00, ram[a]});
    end
    step();
    addr_in = b;
    checks++;
    if (o_busy || o_ack) begin
      failures++;
      $display("FAIL b2b_gap: busy=%b ack=%b need 0 0", o_busy, o_ack);
    end
    step();
    req = 1'b0;
    checks++;
    if (!o_busy || !o_rd || o_addr !== b) begin
      failures++;
      $display("FAIL b2b_second_accept: busy=%b rd=%b addr=%h need 1 1 %h", o_busy, o_rd, o_addr, b);
    end
    step();
    checks++;
    if (!o_ack || o_rdata !== {8'h00, ram[b]}) begin
      failures++;
      $display("FAIL b2b_second: ack=%b rdata=%h need ack=1 rdata=%h", o_ack, o_rdata, {8'h00, ram[b]});
    end
    last_rd[0] = {8'h00, ram[b]};
    step();
    step();
  endtask

  task automatic test_req_ignored();
    run_txn(1, OP_WRB, 16'($urandom), 8'($urandom), 1);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [15:0] a;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      run_txn($urandom_range(0, 1), o, a, 8'($urandom), -1);
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    req = 1'b1; op = OP_RDW; addr_in = 16'($urandom);
    step();
    req = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({if1.rdata, if1.ack, if1.err, if1.busy, if1.arinc_out, if1.mem_addr, if1.mem_wdata, if1.mem_rd, if1.mem_wr} !== '0) begin
      failures++;
      $display("FAIL reset_mid: rdata=%h ack=%b busy=%b rd=%b addr=%h, need all 0", if1.rdata, if1.ack, if1.busy, if1.mem_rd, if1.mem_addr);
    end
    step();
    rst = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (o_ack || o_busy || o_rd) begin
        failures++;
        $display("FAIL reset_no_ack k=%0d: ack=%b busy=%b rd=%b need 0", k, o_ack, o_busy, o_rd);
      end
    end
    run_txn(0, OP_RDB, 16'h0010, 8'h00, -1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    last_rd[0] = '0;
    last_rd[1] = '0;
    test_reset();
    test_byte_read();
    test_word_wrap();
    test_write_w3();
    test_reserved();
    test_back_to_back();
    test_req_ignored();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
